// File: rtl/cpu_core_param.sv
// cpu_core_param: tiny accumulator core (A, B, OUT, carry/zero) executing one ROM instruction per inclk edge.
// Latency: results are visible one edge after issue; out_valid pulses the cycle after an OUT write.
// Backpressure: none; HLT freezes the core until rst_n. Optional macro CPU_IN_SYNC_EN adds a 2-flop in_port synchronizer.
module cpu_core_param #(
   parameter int DATA_W = 4,
   parameter int PC_W   = 4
) (
   input  logic              inclk,
   input  logic              rst_n,
   input  logic [DATA_W+3:0] instr,
   input  logic [DATA_W-1:0] in_port,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] out_port,
   output logic              out_valid,
   output logic              halted,
   output logic              carry,
   output logic              zero
);

   localparam logic [3:0] OP_OUT_Z = 4'hA;  // last opcode that goes through the adder
   localparam logic [3:0] OP_JMP   = 4'hB;
   localparam logic [3:0] OP_JNC   = 4'hC;
   localparam logic [3:0] OP_JZ    = 4'hD;
   localparam logic [3:0] OP_HLT   = 4'hE;

   typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_run;

   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [DATA_W-1:0]   r_out;
   logic [PC_W-1:0]     r_pc;
   logic                r_c;
   logic                r_z;
   logic                r_out_valid;

   logic [3:0]          w_opcode;
   logic [DATA_W-1:0]   w_imm;
   logic [DATA_W-1:0]   w_in;
   logic [DATA_W-1:0]   w_src;
   logic [DATA_W:0]     w_sum;
   logic [PC_W-1:0]     w_pc_inc;
   logic [PC_W-1:0]     w_pc_nxt;

   assign w_opcode = instr[DATA_W+3:DATA_W];
   assign w_imm    = instr[DATA_W-1:0];

`ifdef CPU_IN_SYNC_EN
   logic [DATA_W-1:0]   r_sync1;
   logic [DATA_W-1:0]   r_sync2;

   // Two-flop synchronizer for the asynchronous external input; keeps running while halted.
   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= in_port;
         r_sync2 <= r_sync1;
      end
   end

   assign w_in = r_sync2;
`else
   assign w_in = in_port;
`endif

   // Run/halt state register.
   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_RUN;
      else        r_state <= w_state_nxt;
   end

   // Only HLT leaves RUN; HALT is left by reset alone.
   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_RUN && w_opcode == OP_HLT) w_state_nxt = ST_HALT;
   end

   // Decode state into the execute enable and the halted flag.
   always_comb begin
      w_run  = (r_state == ST_RUN);
      halted = (r_state == ST_HALT);
   end

   // Adder source select: low two opcode bits pick A/B/IN/0 for the A and B groups, OUT group is A/B/0.
   always_comb begin
      w_src = '0;
      case (w_opcode)
         4'h0, 4'h4, 4'h8: w_src = r_a;
         4'h1, 4'h5, 4'h9: w_src = r_b;
         4'h2, 4'h6:       w_src = w_in;
         default:          w_src = '0;
      endcase
   end

   assign w_sum    = {1'b0, w_src} + {1'b0, w_imm};
   assign w_pc_inc = r_pc + PC_W'(1);

   // Next PC: jumps load the low immediate bits, HLT holds, everything else steps (wrapping).
   always_comb begin
      w_pc_nxt = w_pc_inc;
      case (w_opcode)
         OP_JMP:  w_pc_nxt = w_imm[PC_W-1:0];
         OP_JNC:  w_pc_nxt = r_c ? w_pc_inc : w_imm[PC_W-1:0];
         OP_JZ:   w_pc_nxt = r_z ? w_imm[PC_W-1:0] : w_pc_inc;
         OP_HLT:  w_pc_nxt = r_pc;
         default: w_pc_nxt = w_pc_inc;
      endcase
   end

   // Architectural state update; nothing but out_valid's clear happens while halted.
   always_ff @(posedge inclk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_out       <= '0;
         r_c         <= 1'b0;
         r_z         <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         if (w_run) begin
            r_pc <= w_pc_nxt;
            if (w_opcode <= OP_OUT_Z) begin
               r_c <= w_sum[DATA_W];
               r_z <= (w_sum[DATA_W-1:0] == '0);
               if (w_opcode[3]) begin
                  r_out       <= w_sum[DATA_W-1:0];
                  r_out_valid <= 1'b1;
               end else if (w_opcode[2]) begin
                  r_b <= w_sum[DATA_W-1:0];
               end else begin
                  r_a <= w_sum[DATA_W-1:0];
               end
            end
         end
      end
   end

   assign pc        = r_pc;
   assign out_port  = r_out;
   assign out_valid = r_out_valid;
   assign carry     = r_c;
   assign zero      = r_z;

endmodule

// File: doc/cpu_core_param.md
CPU_CORE_PARAM -- requirements
Module: cpu_core_param

Interface
REQ-001 Parameter DATA_W, default 4, datapath/register/immediate width; legal range 4..16.
REQ-002 Parameter PC_W, default 4, program-counter width; SHALL satisfy PC_W <= DATA_W.
REQ-003 inclk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 instr  input  4+DATA_W  instruction word from external program ROM addressed by pc; [DATA_W+3:DATA_W]=opcode, [DATA_W-1:0]=imm.
REQ-006 in_port  input  DATA_W  external data input.
REQ-007 pc  output  PC_W  current program counter.
REQ-008 out_port  output  DATA_W  output register.
REQ-009 out_valid  output  1  single-cycle pulse when out_port is written.
REQ-010 halted  output  1  high while the core is stopped by HLT.
REQ-011 carry, zero  output  1 each  current flag register values.

Function
REQ-012 One instruction per clock; instr treated as combinational on pc, sampled at each rising edge while halted=0.
REQ-013 Registers: A, B, OUT (DATA_W each), PC (PC_W), flags C and Z.
REQ-014 ALU: sum = src + imm, computed at DATA_W+1 bits; result = sum[DATA_W-1:0], C = sum[DATA_W], Z = (result==0).
REQ-015 Opcodes 0x0-0xA (dest<=src+imm): 0 A<=A; 1 A<=B; 2 A<=IN; 3 A<=0; 4 B<=A; 5 B<=B; 6 B<=IN; 7 B<=0; 8 OUT<=A; 9 OUT<=B; A OUT<=0; each SHALL update C and Z.
REQ-016 0xB JMP: PC<=imm[PC_W-1:0]; 0xC JNC: jump if C==0; 0xD JZ: jump if Z==1; jumps SHALL NOT alter flags or data registers.
REQ-017 0xE HLT: halted<=1 next edge; PC, registers, flags frozen thereafter; only reset clears halted.
REQ-018 0xF NOP: PC increment only.
REQ-019 Non-jump and untaken-jump instructions: PC<=PC+1 modulo 2^PC_W (PC=all-ones wraps to 0).
REQ-020 out_valid SHALL be 1 for exactly the cycle after an opcode 8/9/A executes, else 0; back-to-back OUT instructions give consecutive pulses.
REQ-021 Arithmetic wraps silently modulo 2^DATA_W; overflow visible only through C.
REQ-022 While halted=1, out_valid=0 and instr/in_port are ignored.

Reset
REQ-023 rst_n=0 SHALL immediately force PC=0, A=B=OUT=0, C=Z=0, halted=0, out_valid=0, regardless of inclk.
REQ-024 Reset asserted mid-program or while halted SHALL restart execution at PC=0 on the first rising edge after rst_n deasserts.
REQ-025 Synchronizer flops (REQ-026) SHALL also clear to 0 on reset.

Configuration
REQ-026 Macro CPU_IN_SYNC_EN: defined -> in_port passes through a two-flop synchronizer before use by opcodes 2/6 (2-cycle added latency); undefined -> in_port used directly in the same cycle.

Verification
REQ-027 Reset, instr stream {3,5}(A<=5),{8,0}(OUT<=A),{E,0} -> out_port=5, out_valid pulse at cycle 3, halted=1, pc frozen at 2.
REQ-028 Loop: A<=0, then ADD A,1 / JNC 1 -> A counts to 15, wraps to 0 with C=1, JNC falls through at pc=3.
REQ-029 JZ: A<=0xF then ADD A,1 -> Z=1, C=1; JZ 7 -> pc=7; with A<=0xE instead, JZ not taken, pc increments.
REQ-030 PC wrap: 16 NOPs from reset -> pc sequence 0..15,0; no flag or register change.
REQ-031 Async reset asserted mid-cycle while halted -> all outputs 0 immediately; execution resumes at pc=0.
REQ-032 in_port=0x9, opcode 2 imm 0: without CPU_IN_SYNC_EN A=9 one cycle after in_port change; with it, A reflects 9 only if in_port held 2 cycles earlier.
